// File: rtl/bool_truth_sweep.sv
// Stimulus/capture stage for a 3-input boolean block: walks {c,b,a} through 0..7,
// holds each vector HOLD_CYCLES clocks, and captures e into an 8-bit truth table.
module bool_truth_sweep #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       e,
  output logic       busy,
  output logic       done,
  output logic       table_valid,
  output logic [7:0] truth_table,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state_q;
  logic [2:0] idx_q;
  logic [2:0] idx_d;
  logic [7:0] hold_q;
  logic [2:0] vec_q;
  logic       busy_q;
  logic       done_q;
  logic       valid_q;
  logic [7:0] table_q;

  assign idx_d = idx_q + 3'd1;

  // Valid/ready is not used here: start is a level sampled only in IDLE, and
  // abort is a level that cancels only while vectors are being driven.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      hold_q  <= 8'd0;
      vec_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      table_q <= 8'h00;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= DRIVE;
            idx_q   <= 3'd0;
            hold_q  <= 8'd0;
            vec_q   <= 3'd0;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
            table_q <= 8'h00;
          end
        end
        DRIVE: begin
          if (abort) begin
            state_q <= IDLE;
            vec_q   <= 3'd0;
            busy_q  <= 1'b0;
          end else if (hold_q == HOLD_LAST) begin
            // e reflects the vector held since the previous advance.
            table_q[idx_q] <= e;
            hold_q         <= 8'd0;
            if (idx_q == 3'd7) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              valid_q <= 1'b1;
              vec_q   <= 3'd0;
            end else begin
              idx_q <= idx_d;
              vec_q <= idx_d;
            end
          end else begin
            hold_q <= hold_q + 8'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign a           = vec_q[0];
  assign b           = vec_q[1];
  assign c           = vec_q[2];
  assign busy        = busy_q;
  assign done        = done_q;
  assign table_valid = valid_q;
  assign truth_table = table_q;
  assign state_dbg   = state_q;

endmodule
